// File: rtl/spi_byte_target.sv
// SPI mode-0 target front end: oversamples SCK/CS/COPI on CLK, deserialises MSB-first
// bytes and serialises the word assembler's transmit byte onto CIPO.
`timescale 1ns/1ps
module spi_byte_target #(
  parameter int SYNC_STAGES = 3
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       SCK,
  input  logic       CS,
  input  logic       COPI,
  output logic       CIPO,
  input  logic [7:0] tx_byte,
  output logic       tx_latched,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       cs_active,
  output logic       frame_end,
  output logic       frame_partial
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, copi_sync_q, fill_q;
  logic                   sck_prev_q, cs_prev_q, armed_q;
  logic                   sck_s, cs_s, copi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       load_pending_q, load_pending_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_latched_q, tx_latched_d;
  logic       frame_end_q, frame_end_d;
  logic       frame_partial_q, frame_partial_d;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // fill_q marks when the chain holds real samples rather than reset values, so a CS
  // already low at reset release cannot fake a falling edge; CS must be seen high first.
  always_ff @(posedge CLK) begin
    // NOTE: resetn is synchronous (sampled only on CLK); every state register uses <= so
    // all flops update together from pre-edge values regardless of statement order.
    if (!resetn) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
      fill_q      <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      if (fill_q[SYNC_STAGES-1] && cs_s) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      load_pending_q  <= 1'b0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      rx_byte_q       <= '0;
      rx_valid_q      <= 1'b0;
      tx_latched_q    <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_partial_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      load_pending_q  <= load_pending_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_valid_q      <= rx_valid_d;
      tx_latched_q    <= tx_latched_d;
      frame_end_q     <= frame_end_d;
      frame_partial_q <= frame_partial_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned
    // (which would infer a latch); strobes default low so they last exactly one cycle.
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    load_pending_d  = load_pending_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    rx_byte_d       = rx_byte_q;
    rx_valid_d      = 1'b0;
    tx_latched_d    = 1'b0;
    frame_end_d     = 1'b0;
    frame_partial_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d        = ACTIVE;
          bit_cnt_d      = '0;
          load_pending_d = 1'b0;
          tx_shift_d     = tx_byte;
          tx_latched_d   = 1'b1;
        end
      end
      ACTIVE: begin
        // CS deassertion takes priority over any SCK edge detected in the same cycle.
        if (cs_rise) begin
          state_d         = IDLE;
          frame_end_d     = 1'b1;
          frame_partial_d = (bit_cnt_q != 3'd0);
          bit_cnt_d       = '0;
          load_pending_d  = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[5:0], copi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d      = {rx_shift_q, copi_s};
            rx_valid_d     = 1'b1;
            load_pending_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (load_pending_q) begin
            tx_shift_d     = tx_byte;
            tx_latched_d   = 1'b1;
            load_pending_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CIPO          = tx_shift_q[7];
  assign tx_latched    = tx_latched_q;
  assign rx_byte       = rx_byte_q;
  assign rx_valid      = rx_valid_q;
  assign cs_active     = (state_q == ACTIVE);
  assign frame_end     = frame_end_q;
  assign frame_partial = frame_partial_q;

endmodule
